result_reader: RTL and testbench
================================

# result_reader

Drain engine for the results SRAM. It reads a programmed range of result words, each MATRIX_SIZE signed partial sums of PARTIAL_SUM_BW bits, and serializes them onto a valid/ready element stream, lane 0 first. It sits after the vector multiplier's result store, on the read side of the results SRAM port. The port is muxed externally using `busy` as the select.

## Interface
- ADDRESSSIZE, 10, results SRAM address width
- PARTIAL_SUM_BW, 24, bits per result element
- MATRIX_SIZE, 32, elements per SRAM word (≥2)
- WORDSIZE_Result, PARTIAL_SUM_BW*MATRIX_SIZE, SRAM word width

- clk  in  1  clock; all state changes on the rising edge
- rstn  in  1  reset; asynchronous, active-low
- start  in  1  single-cycle request; sampled only in IDLE
- base_addr  in  ADDRESSSIZE  first word address; captured with start
- word_count  in  ADDRESSSIZE+1  number of words to drain; captured with start
- sram_address  out  ADDRESSSIZE  read address to results SRAM
- sram_rd_data  in  WORDSIZE_Result  SRAM data_out; registered read, valid one edge after the address is captured
- out_data  out  PARTIAL_SUM_BW  current element (signed)
- out_valid  out  1  element valid
- out_ready  in  1  consumer accepts; handshake = out_valid & out_ready at an edge
- out_last  out  1  high with the final element of the final word
- busy  out  1  high from the edge after start until the DONE exit
- done  out  1  one-cycle pulse when the drain completes

## Operation
- Reset values: sram_address=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, FSM=IDLE, all counters 0.
- States:
  - IDLE: start → FETCH if word_count≠0; start with word_count==0 → DONE.
  - FETCH: drive the address for one cycle → WAIT.
  - WAIT: one cycle → LOAD.
  - LOAD (edge action): capture sram_rd_data into the shift register, set elem_idx=0 → SHIFT.
  - SHIFT: present element elem_idx. On a handshake, elem_idx++. On the handshake at elem_idx==MATRIX_SIZE-1:
    - words remaining → FETCH (no prefetch);
    - no words remaining → DONE.
  - DONE: pulse done, clear busy → IDLE.
- Element order: elem_idx k drives out_data = word[k*PARTIAL_SUM_BW +: PARTIAL_SUM_BW].
- Backpressure: while out_valid & !out_ready, out_data, out_last and elem_idx hold. sram_address holds, so SRAM output stays stable.
- Address increment: sram_address increments by 1 per word, modulo 2^ADDRESSSIZE; wrap from 1023 to 0 is legal.
- word_count range: 0 to 2^ADDRESSSIZE. A value of 0 produces no elements but still pulses done.
- start while busy is ignored. base_addr and word_count are sampled only on an accepted start.
- rstn deasserted mid-drain aborts immediately to reset values. No done pulse is generated.

## Timing
- start sampled at edge N → sram_address=base_addr after N.
  - SRAM captures it at N+1.
  - Shift register loads at N+2.
  - out_valid=1 after N+2.
- With out_ready held high: one element per cycle; a word drains in MATRIX_SIZE cycles.
- Without prefetch: last handshake of a word at edge M gives out_valid=0 after M and after M+1; the next word is valid after M+2. This is a 2-cycle bubble.
- Final handshake at edge M: out_valid=0 and done=1 after M, done=0 after M+1. busy=0 after M+1.
- out_last=1 only while elem_idx==MATRIX_SIZE-1 of the final word.

## Configuration
- RESULT_READER_PREFETCH_EN defined:
  - At each LOAD edge, if words remain, sram_address advances to the next word in the same cycle.
  - At the last-element handshake, the next word loads directly at that edge. There is no FETCH/WAIT and no bubble.
  - Requires MATRIX_SIZE≥2.
- RESULT_READER_PREFETCH_EN undefined: the FETCH/WAIT path and 2-cycle inter-word bubble apply as described above.
- First-word latency and done timing are identical in both builds.

## Test plan
- Single word: base=5, count=1, out_ready=1, word lanes k=k+1 → out_data 1..32 on 32 consecutive cycles from N+2, out_last with 32, done one cycle later, sram_address=5.
- Three words from base=1022, ready=1 → addresses 1022, 1023, 0 (wrap); 96 elements in order. Without prefetch, two 2-cycle bubbles; with prefetch, 96 contiguous cycles.
- Backpressure: ready toggled 1,0,0,1 repeating, with lane values −1, 0x7FFFFF, 0x800000 → every element is delivered exactly once, unchanged while stalled, and sign patterns are preserved.
- count=0 → no out_valid; done pulses at N+1; busy=1 for exactly one cycle.
- start reasserted while busy with different base/count → ignored; the original drain completes unchanged.
- rstn pulsed low mid-word (elem_idx=10) → all outputs at reset values asynchronously, no done. A fresh start afterwards drains correctly from its own base.

Source files
------------

// File: rtl/result_reader.sv
// result_reader: drains a range of results-SRAM words onto a valid/ready element stream, lane 0 first.
// Define RESULT_READER_PREFETCH_EN to overlap the next word's SRAM read with shifting (no inter-word bubble).
module result_reader #(
  parameter int ADDRESSSIZE     = 10,
  parameter int PARTIAL_SUM_BW  = 24,
  parameter int MATRIX_SIZE     = 32,
  parameter int WORDSIZE_Result = PARTIAL_SUM_BW * MATRIX_SIZE
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [ADDRESSSIZE-1:0]     base_addr,
  input  logic [ADDRESSSIZE:0]       word_count,
  output logic [ADDRESSSIZE-1:0]     sram_address,
  input  logic [WORDSIZE_Result-1:0] sram_rd_data,
  output logic [PARTIAL_SUM_BW-1:0]  out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(MATRIX_SIZE - 1);
  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(MATRIX_SIZE - 2);
  localparam logic [ADDRESSSIZE:0] ONE_WORD = (ADDRESSSIZE + 1)'(1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RD, SHIFT, DONE} state_t;

  state_t                     state;
  logic [WORDSIZE_Result-1:0] shift_reg;
  logic [IDX_W-1:0]           elem_idx;
  logic [ADDRESSSIZE:0]       words_left;
  logic                       final_word;
  logic                       handshake;
  logic                       last_beat;
  logic                       do_load;

  assign handshake = out_valid & out_ready;
  assign last_beat = (state == SHIFT) && handshake && (elem_idx == LAST_IDX);

  // The word load happens on the edge that leaves WAIT_RD; with prefetch it can also
  // happen on the last-element handshake, since the next address was issued at the previous load.
`ifdef RESULT_READER_PREFETCH_EN
  assign do_load = (state == WAIT_RD) || (last_beat && !final_word);
`else
  assign do_load = (state == WAIT_RD);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      sram_address <= '0;
      shift_reg    <= '0;
      elem_idx     <= '0;
      words_left   <= '0;
      final_word   <= 1'b0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sram_address <= base_addr;
            words_left   <= word_count;
            busy         <= 1'b1;
            if (word_count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: state <= WAIT_RD;
        WAIT_RD: ;
        SHIFT: begin
          if (handshake) begin
            if (elem_idx == LAST_IDX) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (final_word) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
`ifndef RESULT_READER_PREFETCH_EN
                sram_address <= sram_address + 1'b1;
                state        <= FETCH;
`endif
              end
            end else begin
              elem_idx  <= elem_idx + 1'b1;
              out_data  <= shift_reg[PARTIAL_SUM_BW-1:0];
              shift_reg <= shift_reg >> PARTIAL_SUM_BW;
              out_last  <= final_word && (elem_idx == PRE_LAST_IDX);
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (do_load) begin
        out_data   <= sram_rd_data[PARTIAL_SUM_BW-1:0];
        shift_reg  <= sram_rd_data >> PARTIAL_SUM_BW;
        elem_idx   <= '0;
        out_valid  <= 1'b1;
        out_last   <= 1'b0;
        words_left <= words_left - 1'b1;
        final_word <= (words_left == ONE_WORD);
        state      <= SHIFT;
`ifdef RESULT_READER_PREFETCH_EN
        if (words_left != ONE_WORD) sram_address <= sram_address + 1'b1;
`endif
      end
    end
  end

  // Stream-protocol invariants: a stalled element never changes, and last/done are well formed.
  assert property (@(posedge clk) disable iff (!rstn)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_last)));
  assert property (@(posedge clk) disable iff (!rstn) out_last |-> out_valid);
  assert property (@(posedge clk) disable iff (!rstn) done |-> (busy && !out_valid));

endmodule

// File: tb/tb_result_reader.sv
// Directed self-checking bench for result_reader with a registered-read SRAM model.
module tb_result_reader;

  localparam int AW  = 10;
  localparam int BW  = 24;
  localparam int MS  = 32;
  localparam int WS  = BW * MS;
`ifdef RESULT_READER_PREFETCH_EN
  localparam int BUBBLE = 0;
`else
  localparam int BUBBLE = 2;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic [AW-1:0] sram_address;
  logic [WS-1:0] sram_rd_data = '0;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [WS-1:0] mem [0:1023];
  int compare_count = 0;
  int fail_count = 0;

  result_reader dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .word_count(word_count),
    .sram_address(sram_address), .sram_rd_data(sram_rd_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sram_rd_data <= mem[sram_address];

  function automatic logic [BW-1:0] laneVal(input int addr, input int lane);
    if (addr == 5) return BW'(lane + 1);
    if (addr == 100 || addr == 101) begin
      case (lane % 3)
        0:       return 24'hFFFFFF;
        1:       return 24'h7FFFFF;
        default: return 24'h800000;
      endcase
    end
    return BW'((addr << 8) | lane) ^ 24'hA00000;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int base, input int count);
    start      = 1'b1;
    base_addr  = AW'(base);
    word_count = (AW + 1)'(count);
    step();
    start      = 1'b0;
  endtask

  // Runs from cycle c0 after the start edge, checking every element, stall stability and timing.
  task automatic drainCheck(input string tag, input int base, input int count, input int ready_mode,
                            input int c0, output int done_cyc, output int gap_cyc, output int first_cyc);
    int elem = 0;
    bit stalled = 0;
    logic [BW-1:0] held_data = '0;
    logic held_last = 1'b0;
    logic [BW-1:0] exp_val;
    done_cyc = -1;
    gap_cyc = 0;
    first_cyc = -1;
    for (int c = c0; c < 4000; c++) begin
      if (stalled)
        checkOutput($sformatf("%s_hold%0d", tag, elem), {out_valid, out_last, out_data}, {1'b1, held_last, held_data});
      if (done) begin
        done_cyc = c;
        break;
      end
      out_ready = (ready_mode == 0) ? 1'b1 : ((c % 4) == 0 || (c % 4) == 3);
      if (out_valid && first_cyc < 0) first_cyc = c;
      if (!out_valid && first_cyc >= 0) gap_cyc++;
      stalled   = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        exp_val = laneVal((base + elem / MS) % 1024, elem % MS);
        checkOutput($sformatf("%s_elem%0d", tag, elem), {out_last, out_data},
                    {(elem == count * MS - 1), exp_val});
        elem++;
      end
      step();
    end
    if (done_cyc < 0) checkOutput({tag, "_timeout"}, 0, 1);
    checkOutput({tag, "_count"}, elem, count * MS);
  endtask

  initial begin
    int dc, gc, fc;
    for (int a = 0; a < 1024; a++)
      for (int l = 0; l < MS; l++)
        mem[a][l*BW +: BW] = laneVal(a, l);

    repeat (2) step();
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_busy_done", {busy, done, out_last}, 0);
    checkOutput("rst_addr_data", {sram_address, out_data}, 0);
    #2 rstn = 1'b1;
    step();

    // single word at 5, lanes hold 1..32
    applyStimulus(5, 1);
    checkOutput("w1_addr", sram_address, 5);
    checkOutput("w1_busy", busy, 1);
    drainCheck("w1", 5, 1, 0, 0, dc, gc, fc);
    checkOutput("w1_first", fc, 2);
    checkOutput("w1_done_cyc", dc, 34);
    checkOutput("w1_done_valid", out_valid, 0);
    checkOutput("w1_addr_end", sram_address, 5);
    step();
    checkOutput("w1_after", {busy, done}, 0);

    // three words across the address wrap
    applyStimulus(1022, 3);
    checkOutput("w3_addr0", sram_address, 1022);
    drainCheck("w3", 1022, 3, 0, 0, dc, gc, fc);
    checkOutput("w3_first", fc, 2);
    checkOutput("w3_done_cyc", dc, 2 + 3 * MS + 2 * BUBBLE);
    checkOutput("w3_gaps", gc, 2 * BUBBLE);
    checkOutput("w3_addr_end", sram_address, 0);
    step();
    checkOutput("w3_after", {busy, done}, 0);

    // backpressure with sign-extreme lanes
    applyStimulus(100, 2);
    drainCheck("bp", 100, 2, 1, 0, dc, gc, fc);
    step();
    checkOutput("bp_after", {busy, done}, 0);

    // zero-length drain
    out_ready = 1'b1;
    applyStimulus(40, 0);
    checkOutput("z_pulse", {done, busy, out_valid}, 3'b110);
    step();
    checkOutput("z_after", {done, busy, out_valid}, 3'b000);
    step();
    checkOutput("z_idle", {done, busy, out_valid}, 3'b000);

    // start while busy must be ignored
    applyStimulus(200, 1);
    start = 1'b1;
    base_addr = AW'(300);
    word_count = (AW + 1)'(2);
    step();
    start = 1'b0;
    checkOutput("ign_addr", sram_address, 200);
    drainCheck("ign", 200, 1, 0, 1, dc, gc, fc);
    checkOutput("ign_done_cyc", dc, 34);
    step();
    checkOutput("ign_after", {busy, done}, 0);

    // asynchronous reset mid-word
    applyStimulus(50, 2);
    out_ready = 1'b1;
    repeat (12) step();
    checkOutput("ar_pre", {out_valid, out_data}, {1'b1, laneVal(50, 10)});
    #2 rstn = 1'b0;
    #1;
    checkOutput("ar_valid", out_valid, 0);
    checkOutput("ar_regs", {busy, done, out_last, sram_address, out_data}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("ar_hold%0d", i), {done, busy, out_valid}, 0);
    end
    #2 rstn = 1'b1;
    step();
    applyStimulus(7, 1);
    checkOutput("ar_new_addr", sram_address, 7);
    drainCheck("ar_new", 7, 1, 0, 0, dc, gc, fc);
    checkOutput("ar_new_done_cyc", dc, 34);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
